// File: rtl/ex_mem_pipe_pkg.sv
// ----------------------------------------------------------------
// ex_mem_pipe_pkg: shared EX/MEM types and access-size helpers. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package ex_mem_pipe_pkg;

  // Encoding equals occupancy so the state drives the count output directly.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic access_misaligned(
    input logic       mem_access,
    input logic [1:0] size,
    input logic [1:0] addr_lo
  );
    logic mis;
    mis = 1'b0;
    if (mem_access) begin
      if (size == SZ_HALF) mis = addr_lo[0];
      else if (size == SZ_WORD) mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_mem_pipe_if.sv
// ----------------------------------------------------------------
// ex_mem_pipe_if: execute-side and memory-side handshake bundle. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

interface ex_mem_pipe_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              iValid;
  logic              oReady;
  logic [DATA_W-1:0] iAluData;
  logic              iAluZero;
  logic [RD_W-1:0]   iRd;
  logic              iRegWrite;
  logic              iMemRead;
  logic              iMemWrite;
  logic [2:0]        iFunct3;
  logic [DATA_W-1:0] iStoreData;
  logic              iFlush;
  logic              oValid;
  logic              iReady;
  logic [DATA_W-1:0] oAluData;
  logic              oZero;
  logic [RD_W-1:0]   oRd;
  logic              oRegWrite;
  logic              oMemRead;
  logic              oMemWrite;
  logic [2:0]        oFunct3;
  logic [DATA_W-1:0] oStoreData;
  logic              oMisaligned;
  logic [1:0]        oCount;

  modport master (
    output iValid, iAluData, iAluZero, iRd, iRegWrite, iMemRead, iMemWrite,
           iFunct3, iStoreData, iFlush, iReady,
    input  oReady, oValid, oAluData, oZero, oRd, oRegWrite, oMemRead,
           oMemWrite, oFunct3, oStoreData, oMisaligned, oCount
  );

  modport slave (
    input  iValid, iAluData, iAluZero, iRd, iRegWrite, iMemRead, iMemWrite,
           iFunct3, iStoreData, iFlush, iReady,
    output oReady, oValid, oAluData, oZero, oRd, oRegWrite, oMemRead,
           oMemWrite, oFunct3, oStoreData, oMisaligned, oCount
  );
endinterface

`default_nettype wire

// File: rtl/ex_mem_pipe_slot.sv
// ----------------------------------------------------------------
// ex_mem_slot: payload register with load enable, async clear. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module ex_mem_slot #(
  parameter int W = 8
) (
  input  wire logic         iClk,
  input  wire logic         iRstN,
  input  wire logic         iLoad,
  input  wire logic [W-1:0] iD,
  output logic      [W-1:0] oQ
);
  logic [W-1:0] data_q;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) data_q <= '0;
    else if (iLoad) data_q <= iD;
  end

  assign oQ = data_q;
endmodule

`default_nettype wire

// File: rtl/ex_mem_pipe.sv
// ----------------------------------------------------------------
// ex_mem_pipe: EX/MEM two-entry skid buffer with flush. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
) (
  input wire logic     iClk,
  input wire logic     iRstN,
  ex_mem_pipe_if.slave bus
);
  localparam int PAY_W = 2 * DATA_W + RD_W + 8;

  pipe_state_e      state_q, state_d;
  logic             load_main, load_skid, main_from_skid;
  logic             ready_w, valid_w, in_fire, out_fire;
  logic             regwrite_w, misaligned_w;
  logic [PAY_W-1:0] in_pay, main_d, main_q, skid_q;

  assign regwrite_w   = bus.iRegWrite & (bus.iRd != '0);
  assign misaligned_w = access_misaligned(bus.iMemRead | bus.iMemWrite,
                                          bus.iFunct3[1:0], bus.iAluData[1:0]);
  assign in_pay = {bus.iAluData, bus.iAluZero, bus.iRd, regwrite_w, bus.iMemRead,
                   bus.iMemWrite, bus.iFunct3, bus.iStoreData, misaligned_w};

  // Handshake flags are a function of state only; iReady never reaches oReady.
  assign ready_w  = (state_q != ST_TWO);
  assign valid_w  = (state_q != ST_EMPTY);
  assign in_fire  = bus.iValid & ready_w;
  assign out_fire = valid_w & bus.iReady;

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) state_q <= ST_EMPTY;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (in_fire) begin
          state_d   = ST_ONE;
          load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (out_fire) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_fire) begin
          state_d        = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins over everything; payload registers simply keep stale data.
    if (bus.iFlush) begin
      state_d   = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pay;

  ex_mem_slot #(.W(PAY_W)) u_main (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iLoad (load_main),
    .iD    (main_d),
    .oQ    (main_q)
  );

  ex_mem_slot #(.W(PAY_W)) u_skid (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iLoad (load_skid),
    .iD    (in_pay),
    .oQ    (skid_q)
  );

  assign bus.oReady = ready_w;
  assign bus.oValid = valid_w;
  assign bus.oCount = state_q;
  assign {bus.oAluData, bus.oZero, bus.oRd, bus.oRegWrite, bus.oMemRead,
          bus.oMemWrite, bus.oFunct3, bus.oStoreData, bus.oMisaligned} = main_q;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_pipe.sv
// ----------------------------------------------------------------
// tb_ex_mem_pipe: directed vector table plus skid/flush/reset/stream checks. Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_ex_mem_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_if #(.DATA_W(32), .RD_W(5)) bus ();

  ex_mem_pipe #(.DATA_W(32), .RD_W(5)) dut (
    .iClk  (clk),
    .iRstN (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic        v;
    logic [31:0] alu;
    logic        z;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [2:0]  f3;
    logic [31:0] sd;
    logic        e_v;
    logic        e_rw;
    logic        e_mis;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(
    input logic v, input logic [31:0] alu, input logic z, input logic [4:0] rd,
    input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
    input logic [31:0] sd, input logic e_v, input logic e_rw, input logic e_mis,
    input logic [1:0] e_cnt);
    vec_t r;
    r.v = v; r.alu = alu; r.z = z; r.rd = rd; r.rw = rw; r.mr = mr; r.mw = mw;
    r.f3 = f3; r.sd = sd; r.e_v = e_v; r.e_rw = e_rw; r.e_mis = e_mis; r.e_cnt = e_cnt;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic z,
                       input logic [4:0] rd, input logic rw, input logic mr,
                       input logic mw, input logic [2:0] f3, input logic [31:0] sd);
    bus.iValid = v; bus.iAluData = alu; bus.iAluZero = z; bus.iRd = rd;
    bus.iRegWrite = rw; bus.iMemRead = mr; bus.iMemWrite = mw;
    bus.iFunct3 = f3; bus.iStoreData = sd;
  endtask

  task automatic beat(input logic v, input logic [31:0] alu);
    drive(v, alu, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
  endtask

  task automatic chk_hs(input string tag, input logic v, input logic r, input logic [1:0] c);
    chk({tag, ".oValid"}, 32'(bus.oValid), 32'(v));
    chk({tag, ".oReady"}, 32'(bus.oReady), 32'(r));
    chk({tag, ".oCount"}, 32'(bus.oCount), 32'(c));
  endtask

  logic [31:0] q[$];

  initial begin
    tbl[0] = mk(1'b1, 32'h10,   1'b0, 5'd3,  1'b1, 1'b0, 1'b0, 3'b000, 32'hA5A5_0000, 1'b1, 1'b1, 1'b0, 2'd1);
    tbl[1] = mk(1'b1, 32'h20,   1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2'd1);
    tbl[2] = mk(1'b1, 32'h1002, 1'b0, 5'd5,  1'b0, 1'b0, 1'b1, 3'b010, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 2'd1);
    tbl[3] = mk(1'b1, 32'h1002, 1'b0, 5'd6,  1'b0, 1'b0, 1'b1, 3'b001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 2'd1);
    tbl[4] = mk(1'b1, 32'h1003, 1'b0, 5'd7,  1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0003, 1'b1, 1'b0, 1'b0, 2'd1);
    tbl[5] = mk(1'b1, 32'h1001, 1'b0, 5'd8,  1'b1, 1'b1, 1'b0, 3'b101, 32'h0000_0004, 1'b1, 1'b1, 1'b1, 2'd1);
    tbl[6] = mk(1'b1, 32'h1003, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 3'b010, 32'h0000_0005, 1'b1, 1'b1, 1'b0, 2'd1);
    tbl[7] = mk(1'b1, 32'h1004, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0006, 1'b1, 1'b1, 1'b0, 2'd1);
    tbl[8] = mk(1'b1, 32'h1006, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0, 3'b110, 32'h0000_0007, 1'b1, 1'b1, 1'b1, 2'd1);
    tbl[9] = mk(1'b0, 32'hFFFF, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0000_0008, 1'b0, 1'b0, 1'b0, 2'd0);

    beat(1'b0, 32'h0);
    bus.iFlush = 1'b0;
    bus.iReady = 1'b1;

    // Reset state, before any clock edge has been seen.
    #2;
    chk_hs("reset", 1'b0, 1'b1, 2'd0);
    chk("reset.oAluData", bus.oAluData, 32'h0);
    chk("reset.oRd", 32'(bus.oRd), 32'h0);
    chk("reset.oRegWrite", 32'(bus.oRegWrite), 32'h0);
    chk("reset.oStoreData", bus.oStoreData, 32'h0);
    chk("reset.oMisaligned", 32'(bus.oMisaligned), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Single-beat-per-cycle vectors with iReady held high.
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].alu, tbl[i].z, tbl[i].rd, tbl[i].rw, tbl[i].mr,
            tbl[i].mw, tbl[i].f3, tbl[i].sd);
      step();
      chk($sformatf("vec%0d.oValid", i), 32'(bus.oValid), 32'(tbl[i].e_v));
      chk($sformatf("vec%0d.oCount", i), 32'(bus.oCount), 32'(tbl[i].e_cnt));
      if (tbl[i].e_v) begin
        chk($sformatf("vec%0d.oAluData", i), bus.oAluData, tbl[i].alu);
        chk($sformatf("vec%0d.oZero", i), 32'(bus.oZero), 32'(tbl[i].z));
        chk($sformatf("vec%0d.oRd", i), 32'(bus.oRd), 32'(tbl[i].rd));
        chk($sformatf("vec%0d.oRegWrite", i), 32'(bus.oRegWrite), 32'(tbl[i].e_rw));
        chk($sformatf("vec%0d.oMemRead", i), 32'(bus.oMemRead), 32'(tbl[i].mr));
        chk($sformatf("vec%0d.oMemWrite", i), 32'(bus.oMemWrite), 32'(tbl[i].mw));
        chk($sformatf("vec%0d.oFunct3", i), 32'(bus.oFunct3), 32'(tbl[i].f3));
        chk($sformatf("vec%0d.oStoreData", i), bus.oStoreData, tbl[i].sd);
        chk($sformatf("vec%0d.oMisaligned", i), 32'(bus.oMisaligned), 32'(tbl[i].e_mis));
      end
    end

    // Back-pressure: A and B held, C refused, then drained in order.
    bus.iReady = 1'b0;
    beat(1'b1, 32'd1); step();
    chk_hs("bp.A", 1'b1, 1'b1, 2'd1);
    chk("bp.A.data", bus.oAluData, 32'd1);
    beat(1'b1, 32'd2); step();
    chk_hs("bp.B", 1'b1, 1'b0, 2'd2);
    chk("bp.B.data", bus.oAluData, 32'd1);
    beat(1'b1, 32'd3); step();
    chk_hs("bp.C", 1'b1, 1'b0, 2'd2);
    chk("bp.C.data", bus.oAluData, 32'd1);
    beat(1'b0, 32'd0);
    bus.iReady = 1'b1;
    step();
    chk_hs("bp.drain1", 1'b1, 1'b1, 2'd1);
    chk("bp.drain1.data", bus.oAluData, 32'd2);
    step();
    chk_hs("bp.drain2", 1'b0, 1'b1, 2'd0);

    // Flush from TWO with an incoming beat present.
    bus.iReady = 1'b0;
    beat(1'b1, 32'hA); step();
    beat(1'b1, 32'hB); step();
    chk_hs("fl.full", 1'b1, 1'b0, 2'd2);
    beat(1'b1, 32'hC);
    bus.iFlush = 1'b1;
    step();
    bus.iFlush = 1'b0;
    chk_hs("fl.after", 1'b0, 1'b1, 2'd0);
    beat(1'b0, 32'h0);
    bus.iReady = 1'b1;
    step();
    chk_hs("fl.idle1", 1'b0, 1'b1, 2'd0);
    step();
    chk_hs("fl.idle2", 1'b0, 1'b1, 2'd0);

    // Asynchronous reset while holding one beat, then first accept after release.
    bus.iReady = 1'b0;
    drive(1'b1, 32'h55, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 3'b010, 32'h66);
    step();
    chk_hs("ar.loaded", 1'b1, 1'b1, 2'd1);
    beat(1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_hs("ar.async", 1'b0, 1'b1, 2'd0);
    chk("ar.async.oAluData", bus.oAluData, 32'h0);
    chk("ar.async.oRd", 32'(bus.oRd), 32'h0);
    chk("ar.async.oStoreData", bus.oStoreData, 32'h0);
    chk("ar.async.oZero", 32'(bus.oZero), 32'h0);
    step();
    rst_n = 1'b1;
    beat(1'b1, 32'h77);
    step();
    chk_hs("ar.first", 1'b1, 1'b1, 2'd1);
    chk("ar.first.data", bus.oAluData, 32'h77);
    beat(1'b0, 32'h0);
    bus.iReady = 1'b1;
    step();
    chk_hs("ar.empty", 1'b0, 1'b1, 2'd0);

    // Random streaming against a reference queue.
    for (int c = 0; c < 400; c++) begin
      logic v, r, in_f, out_f;
      logic [31:0] d;
      v = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      d = $urandom;
      beat(v, d);
      bus.iReady = r;
      chk("rnd.oReady", 32'(bus.oReady), 32'(q.size() < 2));
      in_f  = v && (q.size() < 2);
      out_f = (q.size() > 0) && r;
      if (out_f) void'(q.pop_front());
      if (in_f) q.push_back(d);
      step();
      chk("rnd.oValid", 32'(bus.oValid), 32'(q.size() != 0));
      chk("rnd.oCount", 32'(bus.oCount), 32'(q.size()));
      if (q.size() != 0) chk("rnd.oAluData", bus.oAluData, q[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
